exa_crosb_pkt_gen_with_vcs: RTL and testbench

- Synthesizable exanet packet source that drives one crossbar input port in the VC-enabled crossbar testbench and system.
- Emits header/payload/footer beats on an exanet master interface.
- Packet fields (dest, VC, prio, size) come from an LFSR or from fixed register inputs.
- The footer carries a packet index and the header carries the source id, so downstream consumers can cross-check each packet.

---
 rtl/exanet_crosb_pkg.sv | 45 ++++
 rtl/exa_lfsr16.sv | 23 ++
 rtl/exa_crosb_pkt_gen_with_vcs.sv | 180 ++++++++++++++++++
 tb/tb_exa_crosb_pkt_gen_with_vcs.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exanet_crosb_pkg.sv
// Shared definitions for the exanet crossbar packet generator and its consumers:
// beat field offsets, generator FSM encoding and the payload beat-count rule.
package exanet_crosb_pkg;

    localparam int HDR_SRC_LSB  = 104;
    localparam int HDR_DEST_LSB = 72;
    localparam int HDR_VC_LSB   = 64;
    localparam int HDR_PRIO_LSB = 62;
    localparam int HDR_SIZE_LSB = 48;
    localparam int FTR_IDX_LSB  = 96;
    localparam int PAY_IDX_LSB  = 96;
    localparam int PAY_SRC_LSB  = 88;
    localparam int PAY_BEAT_LSB = 80;

    localparam int MAX_PAYLOAD_WORDS = 16;

    typedef enum logic [2:0] {
        GEN_IDLE = 3'd0,
        GEN_HDR  = 3'd1,
        GEN_PAY  = 3'd2,
        GEN_FTR  = 3'd3,
        GEN_GAP  = 3'd4
    } gen_state_t;

    typedef struct packed {
        gen_state_t  state;
        logic [4:0]  beat;
        logic [7:0]  gap_cnt;
        logic [15:0] lfsr;
    } gen_dbg_t;

    // 16-byte payload words; sizes beyond the legal range saturate at the maximum.
    function automatic logic [4:0] payload_words(input logic [13:0] size);
        logic [13:0] words;
        if (size == 14'd0) begin
            return 5'd0;
        end
        words = ((size - 14'd1) >> 4) + 14'd1;
        if (words > 14'(MAX_PAYLOAD_WORDS)) begin
            return 5'(MAX_PAYLOAD_WORDS);
        end
        return words[4:0];
    endfunction

endpackage

// File: rtl/exa_lfsr16.sv
// 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifting left; advances only on step.
module exa_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        step,
    output logic [15:0] value
);

    logic feedback;

    assign feedback = value[15] ^ value[13] ^ value[12] ^ value[10];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            value <= SEED;
        end else if (step) begin
            value <= {value[14:0], feedback};
        end
    end

endmodule

// File: rtl/exa_crosb_pkt_gen_with_vcs.sv
// Exanet packet source for one crossbar input: header, payload and footer beats
// with fields from an LFSR or fixed inputs, a source id and a per-packet index.
module exa_crosb_pkt_gen_with_vcs
    import exanet_crosb_pkg::*;
#(
    parameter int          input_num  = 4,
    parameter int          output_num = 4,
    parameter int          vc_num     = 4,
    parameter int          prio_num   = 2,
    parameter int          SRC_ID     = 0,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    localparam int         logOutput  = $clog2(output_num),
    localparam int         logVc      = $clog2(vc_num),
    localparam int         logPrio    = $clog2(prio_num)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 i_enable,
    input  logic                 i_random,
    input  logic [13:0]          i_fixed_size,
    input  logic [logOutput-1:0] i_fixed_dest,
    input  logic [logVc-1:0]     i_fixed_vc,
    input  logic [logPrio-1:0]   i_fixed_prio,
    input  logic [7:0]           i_gap,
    input  logic [31:0]          i_pkt_limit,
    output logic                 exa_header_valid,
    input  logic                 exa_header_ready,
    output logic                 exa_payload_valid,
    input  logic                 exa_payload_ready,
    output logic                 exa_footer_valid,
    input  logic                 exa_footer_ready,
    output logic [127:0]         exa_data,
    output logic [logOutput-1:0] o_dest,
    output logic [logVc-1:0]     o_vc,
    output logic [logPrio-1:0]   o_prio,
    output logic [31:0]          o_pkt_count,
    output logic                 o_done,
    output gen_dbg_t             o_dbg
);

    // Source ids live in the crossbar's input range.
    localparam logic [7:0] SRC_BYTE = 8'(SRC_ID % input_num);

    gen_state_t           state;
    logic [15:0]          lfsr;
    logic                 launch;
    logic [13:0]          size_q;
    logic [4:0]           nwords_q;
    logic [4:0]           beat_q;
    logic [7:0]           gap_cnt;
    logic [logOutput-1:0] nxt_dest;
    logic [logVc-1:0]     nxt_vc;
    logic [logPrio-1:0]   nxt_prio;
    logic [13:0]          nxt_size;
    logic                 hdr_hs;
    logic                 pay_hs;
    logic                 ftr_hs;

    exa_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk),
        .resetn (resetn),
        .step   (launch),
        .value  (lfsr)
    );

    // Valid/ready: a beat transfers on a clock edge where its valid and ready are
    // both high; valid and data hold until then, and only one valid is ever high.
    assign exa_header_valid  = (state == GEN_HDR);
    assign exa_payload_valid = (state == GEN_PAY);
    assign exa_footer_valid  = (state == GEN_FTR);

    assign hdr_hs = exa_header_valid  && exa_header_ready;
    assign pay_hs = exa_payload_valid && exa_payload_ready;
    assign ftr_hs = exa_footer_valid  && exa_footer_ready;
    assign launch = (state == GEN_IDLE) && i_enable && !o_done;

    always_comb begin
        if (i_random) begin
            nxt_dest = lfsr[logOutput-1:0];
            nxt_vc   = lfsr[4 +: logVc];
            nxt_prio = lfsr[8 +: logPrio];
            nxt_size = 14'(lfsr[15:8]) + 14'd1;
        end else begin
            nxt_dest = i_fixed_dest;
            nxt_vc   = i_fixed_vc;
            nxt_prio = i_fixed_prio;
            nxt_size = i_fixed_size;
        end
    end

    // Beat contents come from latched fields only, so they hold while stalled.
    always_comb begin
        exa_data = '0;
        case (state)
            GEN_HDR: begin
                exa_data[HDR_SRC_LSB  +: 8]  = SRC_BYTE;
                exa_data[HDR_DEST_LSB +: 8]  = 8'(o_dest);
                exa_data[HDR_VC_LSB   +: 8]  = 8'(o_vc);
                exa_data[HDR_PRIO_LSB +: 2]  = 2'(o_prio);
                exa_data[HDR_SIZE_LSB +: 14] = size_q;
            end
            GEN_PAY: begin
                exa_data[PAY_IDX_LSB  +: 32] = o_pkt_count;
                exa_data[PAY_SRC_LSB  +: 8]  = SRC_BYTE;
                exa_data[PAY_BEAT_LSB +: 8]  = 8'(beat_q);
            end
            GEN_FTR: begin
                exa_data[FTR_IDX_LSB +: 32] = o_pkt_count;
            end
            default: exa_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= GEN_IDLE;
            o_dest      <= '0;
            o_vc        <= '0;
            o_prio      <= '0;
            size_q      <= '0;
            nwords_q    <= '0;
            beat_q      <= '0;
            gap_cnt     <= '0;
            o_pkt_count <= '0;
            o_done      <= 1'b0;
        end else begin
            case (state)
                GEN_IDLE: begin
                    if (launch) begin
                        o_dest   <= nxt_dest;
                        o_vc     <= nxt_vc;
                        o_prio   <= nxt_prio;
                        size_q   <= nxt_size;
                        nwords_q <= payload_words(nxt_size);
                        state    <= GEN_HDR;
                    end
                end
                GEN_HDR: begin
                    if (hdr_hs) begin
                        beat_q <= '0;
                        state  <= (nwords_q != 5'd0) ? GEN_PAY : GEN_FTR;
                    end
                end
                GEN_PAY: begin
                    if (pay_hs) begin
                        if (beat_q == nwords_q - 5'd1) begin
                            state <= GEN_FTR;
                        end else begin
                            beat_q <= beat_q + 5'd1;
                        end
                    end
                end
                GEN_FTR: begin
                    if (ftr_hs) begin
                        o_pkt_count <= o_pkt_count + 32'd1;
                        if ((i_pkt_limit != 32'd0) && (o_pkt_count + 32'd1 == i_pkt_limit)) begin
                            o_done <= 1'b1;
                        end
                        if (i_gap != 8'd0) begin
                            gap_cnt <= i_gap;
                            state   <= GEN_GAP;
                        end else begin
                            state <= GEN_IDLE;
                        end
                    end
                end
                GEN_GAP: begin
                    gap_cnt <= gap_cnt - 8'd1;
                    if (gap_cnt <= 8'd1) begin
                        state <= GEN_IDLE;
                    end
                end
                default: state <= GEN_IDLE;
            endcase
        end
    end

    assign o_dbg = '{state: state, beat: beat_q, gap_cnt: gap_cnt, lfsr: lfsr};

endmodule

// File: tb/tb_exa_crosb_pkt_gen_with_vcs.sv
// Bench for exa_crosb_pkt_gen_with_vcs: a packet-level model predicts every beat,
// a negedge monitor drives ready and compares observed handshakes in order.
module tb_exa_crosb_pkt_gen_with_vcs;
    import exanet_crosb_pkg::*;

    localparam int          INPUT_NUM  = 4;
    localparam int          OUTPUT_NUM = 4;
    localparam int          VC_NUM     = 4;
    localparam int          PRIO_NUM   = 2;
    localparam int          SRC_ID     = 3;
    localparam logic [15:0] SEED       = 16'hACE1;
    localparam int          WAIT_MAX   = 4000;

    logic         clk;
    logic         resetn;
    logic         i_enable;
    logic         i_random;
    logic [13:0]  i_fixed_size;
    logic [1:0]   i_fixed_dest;
    logic [1:0]   i_fixed_vc;
    logic [0:0]   i_fixed_prio;
    logic [7:0]   i_gap;
    logic [31:0]  i_pkt_limit;
    logic         exa_header_valid;
    logic         exa_header_ready;
    logic         exa_payload_valid;
    logic         exa_payload_ready;
    logic         exa_footer_valid;
    logic         exa_footer_ready;
    logic [127:0] exa_data;
    logic [1:0]   o_dest;
    logic [1:0]   o_vc;
    logic [0:0]   o_prio;
    logic [31:0]  o_pkt_count;
    logic         o_done;
    gen_dbg_t     dbg;

    exa_crosb_pkt_gen_with_vcs #(
        .input_num (INPUT_NUM),
        .output_num(OUTPUT_NUM),
        .vc_num    (VC_NUM),
        .prio_num  (PRIO_NUM),
        .SRC_ID    (SRC_ID),
        .LFSR_SEED (SEED)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .i_enable         (i_enable),
        .i_random         (i_random),
        .i_fixed_size     (i_fixed_size),
        .i_fixed_dest     (i_fixed_dest),
        .i_fixed_vc       (i_fixed_vc),
        .i_fixed_prio     (i_fixed_prio),
        .i_gap            (i_gap),
        .i_pkt_limit      (i_pkt_limit),
        .exa_header_valid (exa_header_valid),
        .exa_header_ready (exa_header_ready),
        .exa_payload_valid(exa_payload_valid),
        .exa_payload_ready(exa_payload_ready),
        .exa_footer_valid (exa_footer_valid),
        .exa_footer_ready (exa_footer_ready),
        .exa_data         (exa_data),
        .o_dest           (o_dest),
        .o_vc             (o_vc),
        .o_prio           (o_prio),
        .o_pkt_count      (o_pkt_count),
        .o_done           (o_done),
        .o_dbg            (dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [129:0] got, input logic [129:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model: beats tagged {kind, data}, kind 1=header 2=payload 3=footer
    logic [129:0] exp_q[$];
    logic [15:0]  m_lfsr;
    logic [31:0]  m_count;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic push_packet();
        int sz, d, v, p, lf, words;
        logic [127:0] beat;
        lf = int'(m_lfsr);
        if (i_random) begin
            d  = lf % OUTPUT_NUM;
            v  = (lf / 16) % VC_NUM;
            p  = (lf / 256) % PRIO_NUM;
            sz = (lf / 256) + 1;
        end else begin
            d  = int'(i_fixed_dest);
            v  = int'(i_fixed_vc);
            p  = int'(i_fixed_prio);
            sz = int'(i_fixed_size);
        end
        m_lfsr = lfsr_next(m_lfsr);
        words = (sz + 15) / 16;
        beat = '0;
        beat[111:104] = 8'(SRC_ID);
        beat[79:72]   = 8'(d);
        beat[71:64]   = 8'(v);
        beat[63:62]   = 2'(p);
        beat[61:48]   = 14'(sz);
        exp_q.push_back({2'd1, beat});
        for (int k = 0; k < words; k++) begin
            beat = '0;
            beat[127:96] = m_count;
            beat[95:88]  = 8'(SRC_ID);
            beat[87:80]  = 8'(k);
            exp_q.push_back({2'd2, beat});
        end
        beat = '0;
        beat[127:96] = m_count;
        exp_q.push_back({2'd3, beat});
        m_count = m_count + 32'd1;
    endtask

    // monitor: drives ready, checks handshake rules and the beat stream
    int           ready_pct = 100;
    int           hdr_cnt = 0;
    int           ftr_cnt = 0;
    int           pay_in_pkt = 0;
    int           last_pay_beats = 0;
    int           cyc = 0;
    int           last_ftr_cyc = 0;
    int           exp_idle = 1;
    bit           gap_check = 0;
    bit           have_ftr = 0;
    bit           stalled = 0;
    logic         prev_hv = 1'b0;
    logic [2:0]   prev_v = '0;
    logic [127:0] prev_d = '0;

    function automatic logic pick_ready();
        return ($urandom_range(0, 99) < ready_pct);
    endfunction

    always @(negedge clk) begin
        logic [2:0] vv;
        logic [1:0] kind;
        cyc++;
        if (!resetn) begin
            stalled  = 0;
            prev_hv  = 1'b0;
            have_ftr = 0;
        end else begin
            exa_header_ready  = pick_ready();
            exa_payload_ready = pick_ready();
            exa_footer_ready  = pick_ready();
            vv = {exa_header_valid, exa_payload_valid, exa_footer_valid};
            if (stalled) begin
                check("hold_valid", 130'(vv), 130'(prev_v));
                check("hold_data", 130'(exa_data), 130'(prev_d));
            end
            if (vv != 3'b000) check("one_valid", 130'($countones(vv)), 130'(1));
            if (exa_header_valid && !prev_hv && gap_check && have_ftr)
                check("gap_idle", 130'(cyc - last_ftr_cyc - 1), 130'(exp_idle));
            prev_hv = exa_header_valid;
            kind = 2'd0;
            if (exa_header_valid && exa_header_ready) kind = 2'd1;
            else if (exa_payload_valid && exa_payload_ready) kind = 2'd2;
            else if (exa_footer_valid && exa_footer_ready) kind = 2'd3;
            if (kind != 2'd0) begin
                if (exp_q.size() == 0) check("unexpected_beat", {kind, exa_data}, 130'(0));
                else check("beat", {kind, exa_data}, exp_q.pop_front());
                case (kind)
                    2'd1: begin hdr_cnt++; pay_in_pkt = 0; end
                    2'd2: pay_in_pkt++;
                    default: begin
                        ftr_cnt++;
                        last_pay_beats = pay_in_pkt;
                        last_ftr_cyc = cyc;
                        have_ftr = 1;
                    end
                endcase
            end
            stalled = (exa_header_valid && !exa_header_ready) ||
                      (exa_payload_valid && !exa_payload_ready) ||
                      (exa_footer_valid && !exa_footer_ready);
            prev_v = vv;
            prev_d = exa_data;
        end
    end

    // driver tasks
    task automatic set_fixed(input int sz, input int d, input int v, input int p);
        i_fixed_size = 14'(sz);
        i_fixed_dest = 2'(d);
        i_fixed_vc   = 2'(v);
        i_fixed_prio = 1'(p);
    endtask

    task automatic apply_reset();
        i_enable = 1'b0;
        resetn   = 1'b0;
        exp_q.delete();
        m_lfsr  = SEED;
        m_count = '0;
        repeat (2) @(negedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        #1;
    endtask

    // n packets with enable held, enable dropped while the last header is up
    task automatic run_pkts(input int n);
        int h0, f0, t;
        h0 = hdr_cnt;
        f0 = ftr_cnt;
        for (int i = 0; i < n; i++) push_packet();
        i_enable = 1'b1;
        t = 0;
        do begin
            @(negedge clk); #1; t++;
        end while (!(exa_header_valid && hdr_cnt == h0 + n) && t < WAIT_MAX);
        check("hdr_wait", 130'(t < WAIT_MAX), 130'(1));
        i_enable = 1'b0;
        set_fixed($urandom_range(0, 256), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1));
        t = 0;
        while (ftr_cnt != f0 + n && t < WAIT_MAX) begin
            @(negedge clk); #1; t++;
        end
        check("ftr_wait", 130'(t < WAIT_MAX), 130'(1));
        repeat (10) @(negedge clk);
        #1;
        check("no_relaunch", 130'(hdr_cnt), 130'(h0 + n));
        check("idle_state", 130'(dbg.state), 130'(GEN_IDLE));
    endtask

    initial begin
        int sz, t, f0, h0;
        resetn = 1'b0;
        i_enable = 1'b0;
        i_random = 1'b0;
        i_gap = 8'd0;
        i_pkt_limit = 32'd0;
        set_fixed(0, 0, 0, 0);
        exa_header_ready = 1'b1;
        exa_payload_ready = 1'b1;
        exa_footer_ready = 1'b1;
        m_lfsr = SEED;
        m_count = '0;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_valids", 130'({exa_header_valid, exa_payload_valid, exa_footer_valid}), 130'(0));
        check("rst_data", 130'(exa_data), 130'(0));
        check("rst_fields", 130'({o_dest, o_vc, o_prio}), 130'(0));
        check("rst_count", 130'(o_pkt_count), 130'(0));
        check("rst_done", 130'(o_done), 130'(0));
        check("rst_lfsr", 130'(dbg.lfsr), 130'(SEED));
        check("rst_state", 130'(dbg.state), 130'(GEN_IDLE));
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("idle_no_hdr", 130'(hdr_cnt), 130'(0));

        // fixed zero-size packet
        set_fixed(0, 2, 1, 1);
        run_pkts(1);
        check("zero_pay_beats", 130'(last_pay_beats), 130'(0));
        check("count_one", 130'(o_pkt_count), 130'(m_count));
        check("hold_dest", 130'(o_dest), 130'(2));
        check("hold_vc", 130'(o_vc), 130'(1));
        check("hold_prio", 130'(o_prio), 130'(1));

        // payload beat count boundaries, then random fixed sizes
        for (int i = 0; i < 7; i++) begin
            sz = (i == 0) ? 16 : (i == 1) ? 17 : (i == 2) ? 256 : $urandom_range(0, 256);
            set_fixed(sz, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1));
            run_pkts(1);
            check("pay_beats", 130'(last_pay_beats), 130'((sz + 15) / 16));
        end

        // backpressure, fixed then LFSR fields
        ready_pct = 25;
        set_fixed(100, 1, 3, 0);
        run_pkts(3);
        check("bp_pay_beats", 130'(last_pay_beats), 130'(7));
        i_random = 1'b1;
        run_pkts(3);
        ready_pct = 100;
        check("bp_count", 130'(o_pkt_count), 130'(m_count));

        // reset in the middle of a payload, then the seed sequence repeats
        apply_reset();
        run_pkts(1);
        f0 = ftr_cnt;
        push_packet();
        i_enable = 1'b1;
        t = 0;
        do begin
            @(negedge clk); #1; t++;
        end while (!(exa_payload_valid && exa_data[87:80] == 8'd3 && ftr_cnt == f0) && t < WAIT_MAX);
        check("pay3_wait", 130'(t < WAIT_MAX), 130'(1));
        check("count_pre_rst", 130'(o_pkt_count), 130'(1));
        resetn = 1'b0;
        #1;
        check("midrst_valids", 130'({exa_header_valid, exa_payload_valid, exa_footer_valid}), 130'(0));
        check("midrst_count", 130'(o_pkt_count), 130'(0));
        check("midrst_lfsr", 130'(dbg.lfsr), 130'(SEED));
        i_enable = 1'b0;
        exp_q.delete();
        m_lfsr = SEED;
        m_count = '0;
        repeat (2) @(negedge clk);
        #1 resetn = 1'b1;
        run_pkts(1);
        check("seed_count", 130'(o_pkt_count), 130'(1));

        // packet limit with inter-packet gap
        apply_reset();
        i_random = 1'b0;
        set_fixed($urandom_range(1, 64), 3, 2, 1);
        i_gap = 8'd4;
        i_pkt_limit = 32'd3;
        exp_idle = 5;
        gap_check = 1;
        h0 = hdr_cnt;
        f0 = ftr_cnt;
        for (int i = 0; i < 3; i++) push_packet();
        i_enable = 1'b1;
        t = 0;
        while (ftr_cnt != f0 + 3 && t < WAIT_MAX) begin
            @(negedge clk); #1; t++;
        end
        check("limit_wait", 130'(t < WAIT_MAX), 130'(1));
        check("done_early", 130'(o_done), 130'(0));
        @(negedge clk);
        #1;
        check("done_set", 130'(o_done), 130'(1));
        check("limit_count", 130'(o_pkt_count), 130'(3));
        repeat (30) @(negedge clk);
        #1;
        check("limit_headers", 130'(hdr_cnt), 130'(h0 + 3));
        check("limit_no_valid", 130'(exa_header_valid), 130'(0));
        check("done_sticky", 130'(o_done), 130'(1));
        i_enable = 1'b0;
        gap_check = 0;

        check("exp_empty", 130'(exp_q.size()), 130'(0));
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
